// File: rtl/step_ctrl.sv
// step_ctrl: front-panel step/reset controller for a DLX core.
// Two raw pushbuttons are synchronized and debounced. A step press (or the
// free-run mode) issues a one-cycle STEP_OUT, then the FSM watches IN_INIT_IN
// until the core has left init and come back. A reset press drives a
// fixed-width DLX reset pulse and clears the step counter and error flag.
module step_ctrl #(
    parameter int unsigned DB_CYCLES  = 4,
    parameter int unsigned RST_CYCLES = 3,
    parameter int unsigned TO_CYCLES  = 64
) (
    input  logic        CLK_IN,
    input  logic        RESET_N_IN,
    input  logic        STEP_BTN_IN,
    input  logic        RESET_BTN_IN,
    input  logic        RUN_MODE_IN,
    input  logic        IN_INIT_IN,
    output logic        STEP_OUT,
    output logic        DLX_RESET_OUT,
    output logic        BUSY_OUT,
    output logic        ERR_OUT,
    output logic [15:0] STEP_CNT
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        RESETTING
    } state_t;

    // Terminal counts: each counter starts at 0, so the last value is N-1.
    localparam logic [7:0]  DB_LAST  = 8'(DB_CYCLES - 1);
    localparam logic [7:0]  RST_LAST = 8'(RST_CYCLES - 1);
    localparam logic [15:0] TO_LAST  = 16'(TO_CYCLES - 1);

    // Button index 0 is the step button, index 1 the reset button.
    logic [1:0] btn_raw;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] lvl_q;
    logic [1:0] lvl_d;
    logic [1:0] lvl_prev_q;
    logic [7:0] db_cnt_q [2];
    logic [7:0] db_cnt_d [2];
    logic       step_rise;
    logic       rst_rise;

    state_t      state_q;
    state_t      state_d;
    logic        pending_q;
    logic        pending_d;
    logic        err_q;
    logic        err_d;
    logic [15:0] step_cnt_q;
    logic [15:0] step_cnt_d;
    logic [15:0] to_cnt_q;
    logic [15:0] to_cnt_d;
    logic [7:0]  rst_cnt_q;
    logic [7:0]  rst_cnt_d;

    assign btn_raw = {RESET_BTN_IN, STEP_BTN_IN};

    // Debounce: accept a new level only after DB_CYCLES disagreeing samples in a row.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no latch is inferred.
        lvl_d    = lvl_q;
        db_cnt_d = '{default: 8'd0};
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != lvl_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    lvl_d[b] = sync2_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + 8'd1;
                end
            end
        end
    end

    // Two-flop synchronizers, debounced levels and their one-cycle-old copies.
    always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            lvl_q      <= '0;
            lvl_prev_q <= '0;
            db_cnt_q   <= '{default: 8'd0};
        end else begin
            // NOTE: state updates use <= so every flop samples pre-edge values.
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q;
            db_cnt_q   <= db_cnt_d;
        end
    end

    assign step_rise = lvl_q[0] & ~lvl_prev_q[0];
    assign rst_rise  = lvl_q[1] & ~lvl_prev_q[1];

    // Next-state logic; a reset press overrides everything, including a step press.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q | step_rise;
        err_d      = err_q;
        step_cnt_d = step_cnt_q;
        to_cnt_d   = to_cnt_q;
        rst_cnt_d  = rst_cnt_q;

        if (rst_rise) begin
            state_d    = RESETTING;
            pending_d  = 1'b0;
            err_d      = 1'b0;
            step_cnt_d = 16'd0;
            rst_cnt_d  = 8'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (RUN_MODE_IN) begin
                        // Free-run ignores presses; the core's idle state paces steps.
                        pending_d = 1'b0;
                        if (IN_INIT_IN) begin
                            state_d = ISSUE;
                        end
                    end else if (pending_q) begin
                        // A press landing in the same cycle as the consume is dropped.
                        pending_d = 1'b0;
                        state_d   = ISSUE;
                    end
                end
                ISSUE: begin
                    to_cnt_d = 16'd0;
                    state_d  = WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!IN_INIT_IN) begin
                        state_d = WAIT_DONE;
                    end else if (to_cnt_q == TO_LAST) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + 16'd1;
                    end
                end
                WAIT_DONE: begin
                    if (IN_INIT_IN) begin
                        step_cnt_d = step_cnt_q + 16'd1;
                        state_d    = IDLE;
                    end
                end
                RESETTING: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_d = IDLE;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM state, pending press, sticky error and counters.
    always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            err_q      <= 1'b0;
            step_cnt_q <= 16'd0;
            to_cnt_q   <= 16'd0;
            rst_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            err_q      <= err_d;
            step_cnt_q <= step_cnt_d;
            to_cnt_q   <= to_cnt_d;
            rst_cnt_q  <= rst_cnt_d;
        end
    end

    // Outputs decode straight from flops, so they never glitch on input changes.
    assign STEP_OUT      = (state_q == ISSUE);
    assign DLX_RESET_OUT = (state_q == RESETTING);
    assign BUSY_OUT      = (state_q != IDLE);
    assign ERR_OUT       = err_q;
    assign STEP_CNT      = step_cnt_q;

endmodule

// File: doc/step_ctrl.md
STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 4, meaning the number of consecutive stable synchronized samples required to accept a button level change (range 1..255).
REQ-002 The block SHALL have parameter RST_CYCLES, default 3, meaning the width in clocks of the DLX reset pulse (range 1..255).
REQ-003 The block SHALL have parameter TO_CYCLES, default 64, meaning the clocks to wait for the DLX to leave init after a step before flagging an error (range 1..65535).
REQ-004 The block SHALL have port CLK_IN, input, 1 bit: the single system clock; all flops are rising-edge.
REQ-005 The block SHALL have port RESET_N_IN, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port STEP_BTN_IN, input, 1 bit: raw asynchronous step pushbutton, active-high.
REQ-007 The block SHALL have port RESET_BTN_IN, input, 1 bit: raw asynchronous DLX-reset pushbutton, active-high.
REQ-008 The block SHALL have port RUN_MODE_IN, input, 1 bit: 1 selects free-run, 0 selects single-step; it is synchronous to CLK_IN.
REQ-009 The block SHALL have port IN_INIT_IN, input, 1 bit: the DLX control unit's IN_INIT, where 1 means the DLX is idle in its init state.
REQ-010 The block SHALL have port STEP_OUT, output, 1 bit: a one-cycle step pulse that drives DLX STEP_IN.
REQ-011 The block SHALL have port DLX_RESET_OUT, output, 1 bit: an active-high reset pulse that drives DLX RESET_IN.
REQ-012 The block SHALL have port BUSY_OUT, output, 1 bit: 1 whenever the FSM is not in IDLE.
REQ-013 The block SHALL have port ERR_OUT, output, 1 bit: a sticky flag indicating a step acknowledge timeout.
REQ-014 The block SHALL have port STEP_CNT, output, 16 bits: the count of completed steps.

Function
REQ-015 Each raw button SHALL pass through a 2-flop synchronizer, followed by a per-button debouncer with an 8-bit counter.
REQ-016 The debounced level SHALL toggle only after DB_CYCLES consecutive synchronized samples that differ from it; any matching sample SHALL clear the counter.
REQ-017 A rising edge of the debounced step level SHALL set a one-deep pending flag; edges arriving while the flag is already set SHALL be dropped.
REQ-018 The FSM SHALL have exactly five states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE and RESETTING.
REQ-019 In IDLE with RUN_MODE_IN=0, the FSM SHALL go to ISSUE when pending=1, clearing pending.
REQ-020 In IDLE with RUN_MODE_IN=1, the FSM SHALL go to ISSUE when IN_INIT_IN=1; pending SHALL be ignored and cleared.
REQ-021 In ISSUE, STEP_OUT SHALL be 1 for exactly one cycle, and the FSM SHALL go to WAIT_ACK unconditionally; STEP_OUT SHALL be 0 in every other state.
REQ-022 In WAIT_ACK, IN_INIT_IN=0 SHALL move the FSM to WAIT_DONE.
REQ-023 In WAIT_ACK, if a 16-bit timeout counter reaches TO_CYCLES while IN_INIT_IN is still 1, the FSM SHALL set ERR_OUT and return to IDLE without incrementing STEP_CNT.
REQ-024 In WAIT_DONE, IN_INIT_IN=1 SHALL increment STEP_CNT modulo 2^16 (0xFFFF wraps to 0x0000) and return the FSM to IDLE; WAIT_DONE SHALL have no timeout.
REQ-025 A rising edge of the debounced reset level SHALL force RESETTING from any state on the next clock.
REQ-026 Entering RESETTING SHALL clear pending, ERR_OUT and STEP_CNT.
REQ-027 DLX_RESET_OUT SHALL be 1 for exactly RST_CYCLES cycles, after which the FSM SHALL go to IDLE.
REQ-028 A reset edge SHALL take priority over a simultaneous step edge; the step edge SHALL be discarded.
REQ-029 A reset edge arriving during RESETTING SHALL restart the RST_CYCLES count.
REQ-030 ERR_OUT SHALL be cleared only by RESETTING or RESET_N_IN; ERR_OUT SHALL NOT block further steps.
REQ-031 Latency in single-step mode SHALL be fixed: STEP_OUT rises exactly DB_CYCLES+3 clock edges after the first edge that samples STEP_BTN_IN high, provided the FSM is in IDLE.
REQ-032 A step edge that arrives while the FSM is busy SHALL be held pending and issued on the first cycle the FSM is back in IDLE.

Reset
REQ-033 While RESET_N_IN=0, all flops SHALL clear asynchronously: FSM=IDLE, STEP_OUT=0, DLX_RESET_OUT=0, BUSY_OUT=0, ERR_OUT=0, STEP_CNT=0x0000, pending=0, synchronizers=0, debounced levels=0, all counters=0.
REQ-034 Deassertion of RESET_N_IN SHALL take effect on the first rising CLK_IN edge after it goes high; no DLX reset pulse SHALL be generated by RESET_N_IN itself.

Verification
REQ-035 With DB_CYCLES=4, hold STEP_BTN_IN high for 10 clocks while IN_INIT_IN=1 -> STEP_OUT is a single pulse 7 edges after the first sampled high.
REQ-036 With IN_INIT_IN driven low 2 cycles after STEP_OUT and high 5 cycles later -> STEP_CNT goes 0->1, BUSY_OUT deasserts the same cycle, and ERR_OUT stays 0.
REQ-037 With STEP_BTN_IN toggling every 2 clocks for 20 clocks (DB_CYCLES=4) -> no STEP_OUT pulse.
REQ-038 With IN_INIT_IN held at 1 after STEP_OUT and TO_CYCLES=64 -> ERR_OUT=1 after 64 cycles, FSM returns to IDLE, and STEP_CNT is unchanged.
REQ-039 With a reset button edge during WAIT_DONE while STEP_CNT=5 -> DLX_RESET_OUT is high for exactly 3 cycles, STEP_CNT=0, and the FSM reaches IDLE.
REQ-040 With RUN_MODE_IN=1 and a DLX model that returns IN_INIT 4 cycles after each step, starting from STEP_CNT=0xFFFE -> consecutive pulses occur and STEP_CNT wraps to 0x0000 after 2 steps.
